// File: rtl/inst_sequencer_pkg.sv
// Shared types for the instruction sequencer: mnemonics, instruction packet
// layouts and the sequencer state encoding.
package inst_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NOP        = 4'h0,
        OP_MATMUL     = 4'h1,
        OP_ACCMOV     = 4'h2,
        OP_LOADMAC    = 4'h3,
        OP_MATMULT    = 4'h4,
        OP_MATADD     = 4'h5,
        OP_MATLOAD    = 4'h6,
        OP_MATSTORE   = 4'h7,
        OP_MAT_UPDATE = 4'h8,
        OP_HALT       = 4'h9,
        OP_REPEAT     = 4'hA
    } opcode_e;

    typedef struct packed {
        logic [3:0]  mnemonic;
        logic [27:0] operands;
    } generic_inst_packet_t;

    typedef struct packed {
        logic [3:0]  mnemonic;
        logic [7:0]  iterations;
        logic [11:0] body_len;
        logic [7:0]  unused;
    } repeat_inst_packet_t;

    typedef union packed {
        logic [31:0]          raw;
        generic_inst_packet_t generic;
        repeat_inst_packet_t  rpt;
    } inst_packet_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_HALTED,
        S_ERROR
    } seq_state_e;

    function automatic logic is_datapath(input logic [3:0] mnemonic);
        return (mnemonic >= OP_MATMUL) && (mnemonic <= OP_MAT_UPDATE);
    endfunction

endpackage

// File: rtl/inst_loop_ctrl.sv
// Single-level REPEAT loop bookkeeping: holds the loop bounds and counter,
// computes the successor pc and flags illegal REPEAT instructions.
module inst_loop_ctrl
    import inst_sequencer_pkg::*;
#(
    parameter int PC_W  = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             rpt_valid,
    input  logic [11:0]      body_len,
    input  logic [CNT_W-1:0] iterations,
    input  logic             advance,
    input  logic             halt,
    input  logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  next_pc,
    output logic             loop_active,
    output logic             err_zero_len,
    output logic             err_nested
);

    logic [PC_W-1:0]  loop_start_q, loop_start_d;
    logic [PC_W-1:0]  loop_end_q, loop_end_d;
    logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
    logic             loop_active_q, loop_active_d;
    logic             at_end;
    logic             load;

    assign at_end       = loop_active_q && (pc == loop_end_q);
    assign err_zero_len = rpt_valid && (body_len == 12'd0);
    assign err_nested   = rpt_valid && loop_active_q;
    assign load         = rpt_valid && !err_zero_len && !err_nested;
    assign loop_active  = loop_active_q;

    // Wrapping is implicit: every pc sum is truncated to PC_W bits.
    assign next_pc = (at_end && (loop_cnt_q != '0)) ? loop_start_q : pc + PC_W'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        loop_start_d  = loop_start_q;
        loop_end_d    = loop_end_q;
        loop_cnt_d    = loop_cnt_q;
        loop_active_d = loop_active_q;
        if (clear) begin
            loop_start_d  = '0;
            loop_end_d    = '0;
            loop_cnt_d    = '0;
            loop_active_d = 1'b0;
        end else if (load) begin
            loop_start_d  = pc + PC_W'(1);
            loop_end_d    = pc + PC_W'(body_len);
            loop_cnt_d    = iterations;
            loop_active_d = 1'b1;
        end else if (halt) begin
            loop_active_d = 1'b0;
        end else if (advance && at_end) begin
            if (loop_cnt_q != '0) loop_cnt_d    = loop_cnt_q - CNT_W'(1);
            else                  loop_active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_start_q  <= '0;
            loop_end_q    <= '0;
            loop_cnt_q    <= '0;
            loop_active_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            loop_start_q  <= loop_start_d;
            loop_end_q    <= loop_end_d;
            loop_cnt_q    <= loop_cnt_d;
            loop_active_q <= loop_active_d;
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Program sequencer: fetches and decodes instruction words, consumes NOP/HALT/
// REPEAT locally and issues datapath instructions over a valid/ready handshake.
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int PC_W  = 12,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    output logic            imem_rd_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    input  logic            inst_ready,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [PC_W-1:0] pc
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     inst_data_q, inst_data_d;
    logic            rd_en_q, rd_en_d;
    logic            inst_valid_q, inst_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    inst_packet_t    pkt;
    logic [3:0]      mnemonic;
    logic            in_decode;
    logic            idle_like;
    logic            loop_clear;
    logic            rpt_valid;
    logic            halt_take;
    logic            advance;
    logic            handshake;
    logic [PC_W-1:0] next_pc;
    logic            loop_active;
    logic            err_zero_len;
    logic            err_nested;

    assign pkt        = inst_packet_t'(imem_rdata);
    assign mnemonic   = pkt.generic.mnemonic;
    assign in_decode  = (state_q == S_DECODE);
    assign idle_like  = (state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR);
    assign loop_clear = idle_like && start;
    assign rpt_valid  = in_decode && (mnemonic == OP_REPEAT);
    assign halt_take  = in_decode && (mnemonic == OP_HALT);
    assign handshake  = (state_q == S_DISPATCH) && inst_ready;
    assign advance    = (in_decode && (mnemonic == OP_NOP)) || handshake;

    inst_loop_ctrl #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) u_loop_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (loop_clear),
        .rpt_valid    (rpt_valid),
        .body_len     (pkt.rpt.body_len),
        .iterations   (CNT_W'(pkt.rpt.iterations)),
        .advance      (advance),
        .halt         (halt_take),
        .pc           (pc_q),
        .next_pc      (next_pc),
        .loop_active  (loop_active),
        .err_zero_len (err_zero_len),
        .err_nested   (err_nested)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_data_d  = inst_data_q;
        rd_en_d      = 1'b0;
        inst_valid_d = inst_valid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        unique case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = start_addr;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (mnemonic == OP_NOP) begin
                    state_d = S_FETCH;
                    pc_d    = next_pc;
                    rd_en_d = 1'b1;
                end else if (mnemonic == OP_HALT) begin
                    state_d = S_HALTED;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (mnemonic == OP_REPEAT && !err_zero_len && !err_nested) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + PC_W'(1);
                    rd_en_d = 1'b1;
                end else if (is_datapath(mnemonic)) begin
                    state_d      = S_DISPATCH;
                    inst_data_d  = imem_rdata;
                    inst_valid_d = 1'b1;
                end else begin
                    // Illegal REPEAT and reserved mnemonics both land here.
                    state_d = S_ERROR;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
            S_DISPATCH: begin
                if (inst_ready) begin
                    state_d      = S_FETCH;
                    pc_d         = next_pc;
                    rd_en_d      = 1'b1;
                    inst_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            inst_data_q  <= '0;
            rd_en_q      <= 1'b0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_data_q  <= inst_data_d;
            rd_en_q      <= rd_en_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign imem_rd_en = rd_en_q;
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: expected dispatches are queued per
// program and popped as handshakes occur.
module tb_inst_sequencer;

    localparam int PC_W = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] start_addr = '0;
    logic            imem_rd_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            inst_valid;
    logic [31:0]     inst_data;
    logic            inst_ready = 1'b1;
    logic            busy;
    logic            done;
    logic            error;
    logic [PC_W-1:0] pc;

    typedef struct {
        logic [PC_W-1:0] addr;
        logic [31:0]     word;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [4096];
    int          n_vec = 0;
    int          n_err = 0;
    int          hs_count = 0;
    int          rd_count = 0;

    inst_sequencer #(.PC_W(PC_W), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshake monitor: sampled on the falling edge, ahead of the transfer edge.
    always @(negedge clk) begin
        if (rst_n && imem_rd_en) rd_count++;
        if (rst_n && inst_valid && inst_ready) begin
            hs_count++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("disp_data", inst_data, e.word);
                check("disp_pc", 32'(pc), 32'(e.addr));
            end
        end
    end

    task automatic push(input logic [PC_W-1:0] addr);
        exp_t e;
        e.addr = addr;
        e.word = mem[addr];
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [PC_W-1:0] addr);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = addr;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_err_clr", 32'(error), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) break;
        end
        check("end_reached", 32'(done || error), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (inst_valid) break;
        end
        check("valid_seen", 32'(inst_valid), 32'd1);
    endtask

    task automatic load_prog_a();
        mem[12'h000] = 32'h1000_00AB;
        mem[12'h001] = 32'h0000_0000;
        mem[12'h002] = 32'h2000_0CD0;
        mem[12'h003] = 32'h9000_0000;
    endtask

    task automatic run_prog_a(input string tag);
        hs_count = 0;
        push(12'h000);
        push(12'h002);
        do_start(12'h000);
        wait_end(100);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'h003);
        check({tag, "_hs"}, hs_count, 2);
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic expect_error(input logic [PC_W-1:0] addr, input string tag);
        do_start(addr);
        wait_end(100);
        check({tag, "_error"}, 32'(error), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        rd_count = 0;
        repeat (10) @(negedge clk);
        check({tag, "_no_fetch"}, rd_count, 0);
        check({tag, "_err_level"}, 32'(error), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hF000_0000;

        // Reset state
        #12;
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Straight-line program with a NOP that must not be dispatched
        load_prog_a();
        inst_ready = 1'b1;
        run_prog_a("prog_a");

        // Back-pressure: hold ready low for five cycles on a MATMUL
        mem[12'h020] = 32'h1000_0020;
        mem[12'h021] = 32'h9000_0000;
        hs_count   = 0;
        inst_ready = 1'b0;
        push(12'h020);
        do_start(12'h020);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_data", inst_data, 32'h1000_0020);
        end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        wait_end(100);
        check("stall_done", 32'(done), 32'd1);
        check("stall_hs", hs_count, 1);
        check("stall_drain", sb.size(), 0);

        // REPEAT N=2 L=2: body runs three times
        mem[12'h010] = 32'hA020_0200;
        mem[12'h011] = 32'h3000_0111;
        mem[12'h012] = 32'h4000_0222;
        mem[12'h013] = 32'h9000_0000;
        hs_count = 0;
        for (int i = 0; i < 3; i++) begin
            push(12'h011);
            push(12'h012);
        end
        do_start(12'h010);
        wait_end(200);
        check("rpt_done", 32'(done), 32'd1);
        check("rpt_hs", hs_count, 6);
        check("rpt_pc", 32'(pc), 32'h013);
        check("rpt_drain", sb.size(), 0);

        // Error cases: zero-length body, nested REPEAT, reserved mnemonic
        mem[12'h030] = 32'hA010_0000;
        expect_error(12'h030, "err_len0");
        mem[12'h040] = 32'hA000_0200;
        mem[12'h041] = 32'hA000_0100;
        expect_error(12'h040, "err_nest");
        mem[12'h050] = 32'hC000_0000;
        expect_error(12'h050, "err_opc");
        run_prog_a("err_restart");

        // Asynchronous reset while a dispatch is stalled
        inst_ready = 1'b0;
        hs_count   = 0;
        do_start(12'h020);
        wait_valid(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(inst_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rd_en", 32'(imem_rd_en), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_hs", hs_count, 0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        run_prog_a("arst_restart");

        // pc wrap from 0xFFF to 0x000
        mem[12'hFFF] = 32'h1000_0FFF;
        mem[12'h000] = 32'h9000_0000;
        hs_count = 0;
        push(12'hFFF);
        do_start(12'hFFF);
        wait_end(100);
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_pc", 32'(pc), 32'h000);
        check("wrap_hs", hs_count, 1);
        check("wrap_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
